mem_load_initiator: RTL and testbench

//  Initiator side of the load_mem/done -> ready/ready2 memory-load handshake.
//  On a start command it drives load_mem and, after a fixed transfer window, done.
//  It then waits for the responder's ready and ready2 acknowledgements, with a
//  per-stage timeout and a bounded retry count. It reports pass/fail to the sequencer above it.

---
 rtl/mem_load_initiator.sv | 155 +++++++++++++++
 tb/tb_mem_load_initiator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_initiator.sv
// rtl/mem_load_initiator.sv - initiator side of the load_mem/done -> ready/ready2 handshake
// Issues a load, closes the transfer window, then waits for two acknowledges with timeout and retry.
module mem_load_initiator #(
  parameter int LOAD_CYCLES = 4,
  parameter int TIMEOUT     = 8,
  parameter int MAX_RETRY   = 2,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          ready,
  input  logic          ready2,
  output logic          load_mem,
  output logic          done,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic [RW-1:0] retries
);

  localparam int CMAX = (LOAD_CYCLES > TIMEOUT) ? LOAD_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] XFER_LAST = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, LOAD, XFER, DONE, WAIT_RDY, WAIT_RDY2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [RW-1:0] retries_n;
  logic          pass_n, fail_n, timed_out, timeout_hit;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    retries_n   = retries;
    pass_n      = 1'b0;
    fail_n      = 1'b0;
    timeout_hit = 1'b0;
    cnt_inc     = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    // cnt counts completed wait cycles, so cnt_inc is the number of the current one
    timed_out   = (cnt_inc >= WAIT_LAST);

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n   = LOAD;
          cnt_n     = '0;
          retries_n = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
        end else if (ready) begin
          state_n = IDLE;
          fail_n  = 1'b1;
        end else if (LOAD_CYCLES == 1) begin
          state_n = DONE;
        end else begin
          state_n = XFER;
          cnt_n   = CW'(1);
        end
      end
      XFER: begin
        if (abort) begin
          state_n = IDLE;
        end else if (ready) begin
          state_n = IDLE;
          fail_n  = 1'b1;
        end else if (cnt >= XFER_LAST) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DONE: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT_RDY;
          cnt_n   = '0;
        end
      end
      WAIT_RDY: begin
        if (abort) begin
          state_n = IDLE;
        end else if (ready && ready2) begin
          state_n = IDLE;
          pass_n  = 1'b1;
        end else if (ready) begin
          state_n = WAIT_RDY2;
          cnt_n   = '0;
        end else if (timed_out) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      WAIT_RDY2: begin
        if (abort) begin
          state_n = IDLE;
        end else if (ready2) begin
          state_n = IDLE;
          pass_n  = 1'b1;
        end else if (timed_out) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout_hit) begin
      cnt_n = '0;
      if (retries < RETRY_MAX) begin
        retries_n = retries + RW'(1);
        state_n   = LOAD;
      end else begin
        state_n = IDLE;
        fail_n  = 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so each pulse lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      retries  <= '0;
      load_mem <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      retries  <= retries_n;
      load_mem <= (state_n == LOAD);
      done     <= (state_n == DONE);
      busy     <= (state_n != IDLE);
      pass     <= pass_n;
      fail     <= fail_n;
    end
  end

endmodule

// File: tb/tb_mem_load_initiator.sv
// tb/tb_mem_load_initiator.sv - self-checking bench for mem_load_initiator
// Directed table, randomized sequences against a timeline model, and an async reset sequence.
module tb_mem_load_initiator;
  localparam int LC = 4, TO = 8, MR = 2, NMAX = 128;

  logic clk = 1'b0;
  logic rst_n, start, abort, ready, ready2;
  logic load_mem, done, busy, pass, fail;
  logic [1:0] retries;

  always #5 clk = ~clk;

  mem_load_initiator #(.LOAD_CYCLES(LC), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready), .ready2(ready2),
    .load_mem(load_mem), .done(done), .busy(busy), .pass(pass), .fail(fail), .retries(retries)
  );

  // mode: 0 early ack at off, 1 ready at wait off + ready2 m later, 2 ready then no ready2, 3 no ready
  typedef struct packed { logic [1:0] mode; logic [7:0] off; logic [7:0] m; } att_t;
  typedef struct packed { att_t [2:0] att; logic [7:0] abort_at; } scen_t;
  typedef struct packed {
    scen_t sc;
    logic [7:0] loads, dones, npass, nfail, ret, end_e;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  bit st_i[NMAX], rd_i[NMAX], r2_i[NMAX], ab_i[NMAX];
  bit lm_x[NMAX], dn_x[NMAX], bz_x[NMAX], ps_x[NMAX], fl_x[NMAX];
  int rt_x[NMAX];
  int n_edges;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic att_t mk_att(input int md, input int of, input int m);
    att_t t;
    t.mode = 2'(md); t.off = 8'(of); t.m = 8'(m);
    return t;
  endfunction

  function automatic vec_t mkv(input att_t a0, input att_t a1, input att_t a2, input int ab,
                               input int ld, input int dn, input int ps, input int fl,
                               input int rt, input int en);
    vec_t v;
    v.sc.att[0] = a0; v.sc.att[1] = a1; v.sc.att[2] = a2; v.sc.abort_at = 8'(ab);
    v.loads = 8'(ld); v.dones = 8'(dn); v.npass = 8'(ps); v.nfail = 8'(fl);
    v.ret = 8'(rt); v.end_e = 8'(en);
    return v;
  endfunction

  // Timeline model: edge L opens attempt, done at L+LC, wait cycle k sampled at L+LC+1+k.
  task automatic build(input scen_t s, input bit noise);
    int L, D, k, m, tmo, endE, A, nret, cnt;
    bit ok, aborted;
    int rty[3];
    att_t t;
    for (int e = 0; e < NMAX; e++) begin
      st_i[e] = 0; rd_i[e] = 0; r2_i[e] = 0; ab_i[e] = 0;
      lm_x[e] = 0; dn_x[e] = 0; bz_x[e] = 0; ps_x[e] = 0; fl_x[e] = 0; rt_x[e] = 0;
    end
    L = 0; endE = -1; ok = 0; nret = 0; tmo = 0;
    st_i[0] = 1;
    for (int a = 0; a <= MR && endE < 0; a++) begin
      t = s.att[a];
      k = int'(t.off); m = int'(t.m);
      lm_x[L] = 1;
      if (t.mode == 2'd0) begin
        rd_i[L + k] = 1; endE = L + k; ok = 0;
        if (noise) for (int e = L + 1; e <= endE; e++) r2_i[e] = 1'($urandom_range(0, 1));
      end else begin
        D = L + LC; dn_x[D] = 1;
        if (t.mode == 2'd3) begin
          tmo = D + 1 + TO;
          if (noise) for (int e = L + 1; e <= tmo; e++) r2_i[e] = 1'($urandom_range(0, 1));
        end else begin
          if (noise) for (int e = L + 1; e <= D + k; e++) r2_i[e] = 1'($urandom_range(0, 1));
          rd_i[D + 1 + k] = 1;
          if (t.mode == 2'd1) begin
            endE = D + 1 + k + m; r2_i[endE] = 1; ok = 1;
            if (noise) for (int e = D + 2 + k; e < endE; e++) rd_i[e] = 1'($urandom_range(0, 1));
          end else begin
            tmo = D + 1 + k + TO;
            if (noise) for (int e = D + 2 + k; e <= tmo; e++) rd_i[e] = 1'($urandom_range(0, 1));
          end
        end
        if (noise) rd_i[D + 1] = 1'($urandom_range(0, 1));
        if (endE < 0) begin
          if (a < MR) begin rty[nret] = tmo; nret++; L = tmo; end
          else begin endE = tmo; ok = 0; end
        end
      end
    end
    A = int'(s.abort_at);
    aborted = (A > 0) && (A <= endE);
    if (aborted) begin
      endE = A; ab_i[A] = 1;
      for (int e = A; e < NMAX; e++) begin lm_x[e] = 0; dn_x[e] = 0; end
    end else begin
      ps_x[endE] = ok; fl_x[endE] = !ok;
    end
    n_edges = endE + 4;
    for (int e = 0; e < n_edges; e++) begin
      bz_x[e] = (e < endE);
      cnt = 0;
      for (int i = 0; i < nret; i++) if (rty[i] <= e && rty[i] < endE) cnt++;
      rt_x[e] = cnt;
      if (noise && e >= 1 && e <= endE) st_i[e] = 1'($urandom_range(0, 1));
      if (noise && e > endE) ab_i[e] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_seq(input string tag, input scen_t s, input bit noise,
                         output int loads, output int dones, output int npass,
                         output int nfail, output int ret, output int end_e);
    build(s, noise);
    loads = 0; dones = 0; npass = 0; nfail = 0; end_e = -1;
    for (int e = 0; e < n_edges; e++) begin
      start = st_i[e]; ready = rd_i[e]; ready2 = r2_i[e]; abort = ab_i[e];
      @(posedge clk); #1;
      chk($sformatf("%s e%0d load_mem", tag, e), int'(load_mem), int'(lm_x[e]));
      chk($sformatf("%s e%0d done", tag, e), int'(done), int'(dn_x[e]));
      chk($sformatf("%s e%0d busy", tag, e), int'(busy), int'(bz_x[e]));
      chk($sformatf("%s e%0d pass", tag, e), int'(pass), int'(ps_x[e]));
      chk($sformatf("%s e%0d fail", tag, e), int'(fail), int'(fl_x[e]));
      chk($sformatf("%s e%0d retries", tag, e), int'(retries), rt_x[e]);
      loads += int'(load_mem); dones += int'(done);
      npass += int'(pass); nfail += int'(fail);
      if (!busy && end_e < 0) end_e = e;
    end
    ret = int'(retries);
    start = 0; ready = 0; ready2 = 0; abort = 0;
  endtask

  vec_t tbl[11];
  scen_t rs;
  int ld, dn, ps, fl, rt, en, r;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; ready = 0; ready2 = 0;
    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset load_mem", int'(load_mem), 0);
    chk("reset done", int'(done), 0);
    chk("reset pass", int'(pass), 0);
    chk("reset fail", int'(fail), 0);
    chk("reset retries", int'(retries), 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    //             attempt0           attempt1           attempt2       abort ld dn ps fl rt end
    tbl[0]  = mkv(mk_att(1, 3, 2), mk_att(3, 0, 0), mk_att(3, 0, 0),  0, 1, 1, 1, 0, 0, 10);
    tbl[1]  = mkv(mk_att(1, 8, 0), mk_att(3, 0, 0), mk_att(3, 0, 0),  0, 1, 1, 1, 0, 0, 13);
    tbl[2]  = mkv(mk_att(3, 0, 0), mk_att(1, 1, 0), mk_att(3, 0, 0),  0, 2, 2, 1, 0, 1, 19);
    tbl[3]  = mkv(mk_att(3, 0, 0), mk_att(3, 0, 0), mk_att(3, 0, 0),  0, 3, 3, 0, 1, 2, 39);
    tbl[4]  = mkv(mk_att(0, 2, 0), mk_att(3, 0, 0), mk_att(3, 0, 0),  0, 1, 0, 0, 1, 0, 2);
    tbl[5]  = mkv(mk_att(1, 3, 2), mk_att(3, 0, 0), mk_att(3, 0, 0),  2, 1, 0, 0, 0, 0, 2);
    tbl[6]  = mkv(mk_att(1, 3, 2), mk_att(3, 0, 0), mk_att(3, 0, 0), 10, 1, 1, 0, 0, 0, 10);
    tbl[7]  = mkv(mk_att(2, 2, 0), mk_att(1, 1, 1), mk_att(3, 0, 0),  0, 2, 2, 1, 0, 1, 22);
    tbl[8]  = mkv(mk_att(1, 1, 8), mk_att(3, 0, 0), mk_att(3, 0, 0),  0, 1, 1, 1, 0, 0, 14);
    tbl[9]  = mkv(mk_att(0, 1, 0), mk_att(3, 0, 0), mk_att(3, 0, 0),  0, 1, 0, 0, 1, 0, 1);
    tbl[10] = mkv(mk_att(0, 4, 0), mk_att(3, 0, 0), mk_att(3, 0, 0),  0, 1, 0, 0, 1, 0, 4);

    for (int i = 0; i < 11; i++) begin
      run_seq($sformatf("tbl%0d", i), tbl[i].sc, 1'b0, ld, dn, ps, fl, rt, en);
      chk($sformatf("tbl%0d load count", i), ld, int'(tbl[i].loads));
      chk($sformatf("tbl%0d done count", i), dn, int'(tbl[i].dones));
      chk($sformatf("tbl%0d pass count", i), ps, int'(tbl[i].npass));
      chk($sformatf("tbl%0d fail count", i), fl, int'(tbl[i].nfail));
      chk($sformatf("tbl%0d retries", i), rt, int'(tbl[i].ret));
      chk($sformatf("tbl%0d end edge", i), en, int'(tbl[i].end_e));
    end

    for (int i = 0; i < 40; i++) begin
      for (int a = 0; a < 3; a++) begin
        r = int'($urandom_range(0, 7));
        rs.att[a].mode = (r == 0) ? 2'd0 : (r <= 3) ? 2'd1 : (r <= 5) ? 2'd2 : 2'd3;
        rs.att[a].off  = (rs.att[a].mode == 2'd0) ? 8'($urandom_range(1, LC))
                                                 : 8'($urandom_range(1, TO));
        rs.att[a].m    = 8'($urandom_range(0, TO));
      end
      rs.abort_at = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 40)) : 8'd0;
      run_seq($sformatf("rnd%0d", i), rs, 1'b1, ld, dn, ps, fl, rt, en);
    end

    // Reset inside WAIT_RDY2 of a retried attempt while start is held the whole time.
    ld = 0;
    for (int e = 0; e <= 21; e++) begin
      start = 1; ready = (e == 19); ready2 = 0; abort = 0;
      @(posedge clk); #1;
      ld += int'(load_mem);
    end
    chk("rst_seq busy before reset", int'(busy), 1);
    chk("rst_seq retries before reset", int'(retries), 1);
    chk("rst_seq loads with start held", ld, 2);
    #3 rst_n = 0; start = 0; ready = 0;
    #1;
    chk("rst_seq busy async", int'(busy), 0);
    chk("rst_seq retries async", int'(retries), 0);
    chk("rst_seq load_mem async", int'(load_mem), 0);
    chk("rst_seq pass/fail async", int'(pass) + int'(fail), 0);
    @(posedge clk); #1 rst_n = 1;
    ld = 0; dn = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      ld += int'(load_mem); dn += int'(busy);
    end
    chk("rst_seq no relaunch load_mem", ld, 0);
    chk("rst_seq no relaunch busy", dn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
